// File: rtl/mac_seq.sv
// Sequential radix-4 shift-add multiply-accumulate unit with valid/ready handshakes.
// Define MAC_SATURATE_EN to saturate the accumulator on overflow instead of wrapping.
module mac_seq #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 2*WIDTH+4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_clr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod,
  output logic [ACC_W-1:0]   out_acc,
  output logic               out_ovf,
  output logic               busy
);

  localparam int DIGITS = WIDTH/2;
  localparam int KW     = $clog2(DIGITS) + 1;

  typedef enum logic [1:0] {IDLE, MUL, ACC, HOLD} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_reg, b_reg;
  logic               clr_reg;
  logic [KW-1:0]      k;
  logic [2*WIDTH-1:0] partial, prod_reg;
  logic [ACC_W-1:0]   acc;
  logic               ovf;

  logic [WIDTH+1:0]   a_ext, slice;
  logic [2*WIDTH-1:0] slice_shifted;
  logic [ACC_W:0]     sum;
  logic               last_digit;

  // b_reg shifts right each MUL cycle, so its low two bits are always the current digit.
  always_comb begin
    a_ext = {2'b00, a_reg};
    slice = '0;
    case (b_reg[1:0])
      2'd0:    slice = '0;
      2'd1:    slice = a_ext;
      2'd2:    slice = a_ext << 1;
      default: slice = a_ext + (a_ext << 1);
    endcase
    slice_shifted = (2*WIDTH)'(slice) << {k, 1'b0};
    sum           = {1'b0, acc} + (ACC_W+1)'(partial);
    last_digit    = (k == KW'(DIGITS-1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)   state_nxt = MUL;
      MUL:     if (last_digit) state_nxt = ACC;
      ACC:                     state_nxt = HOLD;
      HOLD:    if (out_ready)  state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      clr_reg  <= 1'b0;
      k        <= '0;
      partial  <= '0;
      prod_reg <= '0;
      acc      <= '0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg   <= in_a;
            b_reg   <= in_b;
            clr_reg <= in_clr;
            partial <= '0;
            k       <= '0;
          end
        end
        MUL: begin
          partial <= partial + slice_shifted;
          b_reg   <= b_reg >> 2;
          k       <= k + KW'(1);
        end
        ACC: begin
          prod_reg <= partial;
          if (clr_reg) begin
            acc <= ACC_W'(partial);
            ovf <= 1'b0;
          end else if (sum[ACC_W]) begin
            ovf <= 1'b1;
`ifdef MAC_SATURATE_EN
            acc <= '1;
`else
            acc <= sum[ACC_W-1:0];
`endif
          end else begin
            acc <= sum[ACC_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == HOLD);
  assign out_prod  = prod_reg;
  assign out_acc   = acc;
  assign out_ovf   = ovf;

endmodule

// File: tb/tb_mac_seq.sv
// Directed self-checking bench for mac_seq (WIDTH=8) plus model-checked sweeps at WIDTH=4 and WIDTH=16.
module tb_mac_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Main instance, WIDTH=8, ACC_W=20
  logic        in_valid, in_ready, in_clr, out_valid, out_ready, out_ovf, busy;
  logic [7:0]  in_a, in_b;
  logic [15:0] out_prod;
  logic [19:0] out_acc;

  mac_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_clr(in_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_prod(out_prod), .out_acc(out_acc),
    .out_ovf(out_ovf), .busy(busy)
  );

  // WIDTH=4 instance, ACC_W=12
  logic        w4_in_valid, w4_in_ready, w4_in_clr, w4_out_valid, w4_out_ready, w4_out_ovf, w4_busy;
  logic [3:0]  w4_in_a, w4_in_b;
  logic [7:0]  w4_out_prod;
  logic [11:0] w4_out_acc;

  mac_seq #(.WIDTH(4)) dut_w4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(w4_in_valid), .in_ready(w4_in_ready), .in_a(w4_in_a), .in_b(w4_in_b), .in_clr(w4_in_clr),
    .out_valid(w4_out_valid), .out_ready(w4_out_ready), .out_prod(w4_out_prod), .out_acc(w4_out_acc),
    .out_ovf(w4_out_ovf), .busy(w4_busy)
  );

  // WIDTH=16 instance, ACC_W=36
  logic        w16_in_valid, w16_in_ready, w16_in_clr, w16_out_valid, w16_out_ready, w16_out_ovf, w16_busy;
  logic [15:0] w16_in_a, w16_in_b;
  logic [31:0] w16_out_prod;
  logic [35:0] w16_out_acc;

  mac_seq #(.WIDTH(16)) dut_w16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(w16_in_valid), .in_ready(w16_in_ready), .in_a(w16_in_a), .in_b(w16_in_b), .in_clr(w16_in_clr),
    .out_valid(w16_out_valid), .out_ready(w16_out_ready), .out_prod(w16_out_prod), .out_acc(w16_out_acc),
    .out_ovf(w16_out_ovf), .busy(w16_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Issue one transaction on the WIDTH=8 unit and wait (bounded) for out_valid, leaving it in HOLD.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic clr);
    int cyc;
    in_a = a; in_b = b; in_clr = clr; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_a = ~a; in_b = ~b; in_clr = ~clr;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    checkOutput("latency_w8", 64'(cyc), 64'd5);
  endtask

  task automatic releaseResult();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("release_out_valid", 64'(out_valid), 64'd0);
    checkOutput("release_in_ready", 64'(in_ready), 64'd1);
  endtask

  // Reference accumulator step shared by the sweeps.
  task automatic modelStep(input int accw, input logic [63:0] p, input bit clr,
                           inout logic [63:0] macc, inout bit movf);
    logic [63:0] s;
    logic [63:0] mask;
    mask = (64'd1 << accw) - 64'd1;
    if (clr) begin
      macc = p;
      movf = 1'b0;
    end else begin
      s = macc + p;
      if ((s >> accw) != 64'd0) begin
        movf = 1'b1;
`ifdef MAC_SATURATE_EN
        macc = mask;
`else
        macc = s & mask;
`endif
      end else begin
        macc = s;
      end
    end
  endtask

  task automatic runW4(input int n);
    logic [63:0] macc;
    bit          movf;
    logic [3:0]  a, b;
    bit          clr;
    int          cyc;
    macc = 0; movf = 0;
    for (int i = 0; i < n; i++) begin
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      clr = (i == 0) || ($urandom_range(0, 31) == 0);
      modelStep(12, 64'(a) * 64'(b), clr, macc, movf);
      w4_in_a = a; w4_in_b = b; w4_in_clr = clr; w4_in_valid = 1'b1;
      tick();
      w4_in_valid = 1'b0; w4_in_a = ~a; w4_in_b = ~b;
      cyc = 0;
      while (w4_out_valid !== 1'b1 && cyc < 40) begin
        tick();
        cyc++;
      end
      checkOutput("w4_latency", 64'(cyc), 64'd3);
      checkOutput("w4_prod", 64'(w4_out_prod), 64'(a) * 64'(b));
      checkOutput("w4_acc", 64'(w4_out_acc), macc);
      checkOutput("w4_ovf", 64'(w4_out_ovf), 64'(movf));
      w4_out_ready = 1'b1;
      tick();
      w4_out_ready = 1'b0;
    end
  endtask

  task automatic runW16(input int n);
    logic [63:0] macc;
    bit          movf;
    logic [15:0] a, b;
    bit          clr;
    int          cyc;
    macc = 0; movf = 0;
    for (int i = 0; i < n; i++) begin
      a = 16'($urandom_range(0, 65535));
      b = 16'($urandom_range(0, 65535));
      clr = (i == 0) || ($urandom_range(0, 31) == 0);
      modelStep(36, 64'(a) * 64'(b), clr, macc, movf);
      w16_in_a = a; w16_in_b = b; w16_in_clr = clr; w16_in_valid = 1'b1;
      tick();
      w16_in_valid = 1'b0; w16_in_a = ~a; w16_in_b = ~b;
      cyc = 0;
      while (w16_out_valid !== 1'b1 && cyc < 40) begin
        tick();
        cyc++;
      end
      checkOutput("w16_latency", 64'(cyc), 64'd9);
      checkOutput("w16_prod", 64'(w16_out_prod), 64'(a) * 64'(b));
      checkOutput("w16_acc", 64'(w16_out_acc), macc);
      checkOutput("w16_ovf", 64'(w16_out_ovf), 64'(movf));
      w16_out_ready = 1'b1;
      tick();
      w16_out_ready = 1'b0;
    end
  endtask

  initial begin
    int stray;
    logic [15:0] held_prod;
    logic [19:0] held_acc;

    rst_n = 1'b0;
    in_valid = 0; in_a = 0; in_b = 0; in_clr = 0; out_ready = 0;
    w4_in_valid = 0; w4_in_a = 0; w4_in_b = 0; w4_in_clr = 0; w4_out_ready = 0;
    w16_in_valid = 0; w16_in_a = 0; w16_in_b = 0; w16_in_clr = 0; w16_out_ready = 0;
    tick(); tick();
    rst_n = 1'b1;

    $display("[TB] reset state");
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_acc", 64'(out_acc), 64'd0);
    checkOutput("rst_out_ovf", 64'(out_ovf), 64'd0);
    checkOutput("rst_out_prod", 64'(out_prod), 64'd0);

    $display("[TB] basic multiply");
    applyStimulus(8'd15, 8'd15, 1'b1);
    checkOutput("basic_prod", 64'(out_prod), 64'd225);
    checkOutput("basic_acc", 64'(out_acc), 64'd225);
    releaseResult();

    $display("[TB] reset mid-MUL");
    in_a = 8'd100; in_b = 8'd100; in_clr = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    checkOutput("mid_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_out_acc", 64'(out_acc), 64'd0);
    checkOutput("midrst_out_ovf", 64'(out_ovf), 64'd0);
    checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid !== 1'b0) stray++;
    end
    checkOutput("midrst_stray_results", 64'(stray), 64'd0);

    $display("[TB] accumulate chain");
    applyStimulus(8'd255, 8'd255, 1'b1);
    checkOutput("chain1_prod", 64'(out_prod), 64'd65025);
    checkOutput("chain1_acc", 64'(out_acc), 64'd65025);
    releaseResult();
    applyStimulus(8'd3, 8'd7, 1'b0);
    checkOutput("chain2_prod", 64'(out_prod), 64'd21);
    checkOutput("chain2_acc", 64'(out_acc), 64'd65046);
    releaseResult();
    applyStimulus(8'd0, 8'd200, 1'b0);
    checkOutput("chain3_prod", 64'(out_prod), 64'd0);
    checkOutput("chain3_acc", 64'(out_acc), 64'd65046);
    checkOutput("chain3_ovf", 64'(out_ovf), 64'd0);
    releaseResult();

    $display("[TB] backpressure");
    applyStimulus(8'd12, 8'd10, 1'b1);
    held_prod = out_prod;
    held_acc  = out_acc;
    checkOutput("bp_prod", 64'(out_prod), 64'd120);
    checkOutput("bp_acc", 64'(out_acc), 64'd120);
    in_a = 8'd9; in_b = 8'd9; in_clr = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
      checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
      checkOutput("bp_prod_stable", 64'(out_prod), 64'(held_prod));
      checkOutput("bp_acc_stable", 64'(out_acc), 64'(held_acc));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid = 1'b0;
    checkOutput("bp_release_valid", 64'(out_valid), 64'd0);
    checkOutput("bp_release_busy", 64'(busy), 64'd0);
    checkOutput("bp_release_ready", 64'(in_ready), 64'd1);
    tick();
    checkOutput("bp_no_accept_busy", 64'(busy), 64'd0);
    checkOutput("bp_acc_after", 64'(out_acc), 64'd120);

    $display("[TB] overflow");
    applyStimulus(8'd255, 8'd255, 1'b1);
    releaseResult();
    for (int i = 1; i <= 15; i++) begin
      applyStimulus(8'd255, 8'd255, 1'b0);
      releaseResult();
    end
    checkOutput("ovf_pre_flag", 64'(out_ovf), 64'd0);
    checkOutput("ovf_pre_acc", 64'(out_acc), 64'd1040400);
    applyStimulus(8'd255, 8'd255, 1'b0);
    checkOutput("ovf_flag", 64'(out_ovf), 64'd1);
`ifdef MAC_SATURATE_EN
    checkOutput("ovf_acc", 64'(out_acc), 64'd1048575);
`else
    checkOutput("ovf_acc", 64'(out_acc), 64'd56849);
`endif
    releaseResult();
    applyStimulus(8'd1, 8'd1, 1'b0);
    checkOutput("ovf_sticky", 64'(out_ovf), 64'd1);
`ifdef MAC_SATURATE_EN
    checkOutput("ovf_sticky_acc", 64'(out_acc), 64'd1048575);
`else
    checkOutput("ovf_sticky_acc", 64'(out_acc), 64'd56850);
`endif
    releaseResult();
    applyStimulus(8'd2, 8'd3, 1'b1);
    checkOutput("clr_acc", 64'(out_acc), 64'd6);
    checkOutput("clr_ovf", 64'(out_ovf), 64'd0);
    checkOutput("clr_prod", 64'(out_prod), 64'd6);
    releaseResult();

    $display("[TB] sweep WIDTH=4");
    runW4(1000);
    $display("[TB] sweep WIDTH=16");
    runW16(1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mac_seq.md
Name: mac_seq

Overview:
- Parametrised sequential multiply-accumulate unit; next generation of the MAC datapath after the fixed 4-bit combinational multiplier.
- Unsigned WIDTH x WIDTH multiply using an iterative radix-4 shift-add datapath. Each cycle processes one 2-bit digit of the multiplier, reusing a single 2-bit partial-product slice instead of a full array.
- Product is added into a wide accumulator. Operands enter and results leave over valid/ready handshakes.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 4.
- ACC_W, 2*WIDTH+4, accumulator width; must be >= 2*WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  operand transfer request.
- in_ready  output  1  unit can accept operands.
- in_a  input  WIDTH  multiplicand, unsigned.
- in_b  input  WIDTH  multiplier, unsigned.
- in_clr  input  1  1 = this product replaces the accumulator; 0 = product is added to it.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_prod  output  2*WIDTH  product of the last transaction.
- out_acc  output  ACC_W  accumulator value after the last transaction.
- out_ovf  output  1  sticky accumulator overflow flag.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n=0 at a clk edge) takes priority over everything:
  - state=IDLE; partial-product, accumulator, out_prod, out_acc and out_ovf all 0; out_valid=0.
  - In-flight operation is discarded with no output.
  - in_ready=1 and busy=0 from the first cycle after reset.
- FSM states IDLE, MUL, ACC, HOLD. Outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- IDLE:
  - in_ready=1.
  - On in_valid=1: latch in_a, in_b, in_clr; clear partial and digit counter k; go to MUL.
- MUL:
  - in_ready=0.
  - Each cycle: partial += (a * b[2k+1:2k]) << 2k, then k += 1. Arithmetic is 2*WIDTH bits and never overflows.
  - After WIDTH/2 cycles (k = WIDTH/2-1 processed), go to ACC.
- ACC (one cycle):
  - out_prod <= partial.
  - If clr=1: acc <= zero-extended partial, and ovf <= 0.
  - Otherwise: sum = acc + zero-extended partial, computed ACC_W+1 bits wide.
  - If the carry-out is set: ovf <= 1, and acc is updated per the Optional Feature. Otherwise acc <= sum.
  - Go to HOLD.
- HOLD:
  - out_valid=1; out_acc and out_prod stable; in_ready=0.
  - On out_ready=1: out_valid drops next cycle and state returns to IDLE.
  - No new operand is accepted in the same cycle as the result transfer.
- Latency: out_valid rises WIDTH/2+1 cycles after the accepting edge (5 cycles for WIDTH=8).
- Minimum issue interval: WIDTH/2+3 cycles.
- out_acc and out_ovf hold their values across IDLE, so the accumulator persists between transactions.
- Inputs other than in_valid are ignored outside IDLE. Operand changes during MUL have no effect.
- out_ready is ignored when out_valid=0.
- Zero operands are processed normally, still taking the full WIDTH/2 MUL cycles; no early exit.
- Accumulator wraps modulo 2^ACC_W unless the Optional Feature is compiled in.

Optional Feature:
- Macro: MAC_SATURATE_EN.
- Defined: on an accumulate carry-out, acc <= all ones (2^ACC_W-1). Once saturated, acc stays saturated until a clr transaction or reset. out_ovf is set as normal.
- Undefined: acc <= sum modulo 2^ACC_W (wrap-around). out_ovf is set identically.
- clr transactions behave identically in both builds.

Test Plan:
- Reset mid-MUL: assert rst_n=0 for one edge during the MUL state.
  - Required: out_valid=0, out_acc=0, out_ovf=0, in_ready=1 next cycle, and no stray result appears.
- Basic multiply (WIDTH=8): a=15, b=15, clr=1.
  - Required: out_valid exactly 5 cycles after acceptance; out_prod=225; out_acc=225.
- Accumulate chain: (255,255,clr=1), then (3,7,clr=0), then (0,200,clr=0).
  - Required: out_acc = 65025, then 65046, then 65046.
  - Required: out_prod = 65025, then 21, then 0.
- Backpressure: hold out_ready=0 for 10 cycles in HOLD, then 1.
  - Required: out_valid stays 1 and outputs stay stable; in_ready=0 throughout; return to IDLE one cycle after out_ready=1.
- Overflow (WIDTH=8, ACC_W=20): (255,255,clr=1), then 16 further (255,255,clr=0).
  - Required: the 16th accumulating transaction (17th overall) sets out_ovf=1.
  - Without MAC_SATURATE_EN: out_acc=56849. With MAC_SATURATE_EN: out_acc=1048575.
  - A following (2,3,clr=1) gives out_acc=6 and out_ovf=0.
- Parameter sweep: WIDTH=4 and WIDTH=16, 1000 random operand/clr sequences each.
  - Required: results match a reference model; latency is WIDTH/2+1.
